// File: rtl/sync_fifo_pkg.sv
// +-----------------------------------------------------------------------------
// | sync_fifo_pkg : shared types and sizing helpers for sync_fifo_pkt
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package sync_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PKT     = 2'd1,
        DISCARD = 2'd2
    } fifo_state_t;

    // Stored beat is {last, data}
    function automatic int beat_width(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int fifo_depth(input int addr_width);
        return 2 ** addr_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_pkt_mem.sv
// +-----------------------------------------------------------------------------
// | sync_fifo_pkt_mem : flop-based storage, one write port, async read port
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module sync_fifo_pkt_mem
    import sync_fifo_pkg::*;
#(
    parameter int WORD_WIDTH = 33,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WORD_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WORD_WIDTH-1:0] o_rdata
);

    localparam int c_depth = fifo_depth(ADDR_WIDTH);

    logic [WORD_WIDTH-1:0] r_mem [c_depth];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_pkt.sv
// +-----------------------------------------------------------------------------
// | sync_fifo_pkt : FWFT stream FIFO with optional whole-packet commit/drop
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module sync_fifo_pkt
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter bit PKT_MODE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_drop,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic [ADDR_WIDTH:0]   afull_thr,
    input  logic [ADDR_WIDTH+1:0] aempty_thr,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   wr_uw,
    output logic [ADDR_WIDTH+1:0] rd_uw,
    output logic [ADDR_WIDTH+1:0] pkt_cnt,
    output logic                  ovf_err,
    output logic                  drop_err,
    input  logic                  err_clr
);

    localparam int                c_beat_w   = beat_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] c_full_cnt = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH:0]   r_wr_ptr, r_cmt_ptr, r_rd_ptr;
    logic [ADDR_WIDTH+1:0] r_pkt_cnt;
    fifo_state_t           r_state;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_m_last, r_m_valid;
    logic                  r_ovf_err, r_drop_err;

    logic [ADDR_WIDTH:0]   w_wr_uw, w_uncmt, w_cmt_cnt, w_wr_ptr_nxt;
    logic [ADDR_WIDTH+1:0] w_rd_uw;
    logic [c_beat_w-1:0]   w_rd_word;
    logic                  w_full, w_s_ready, w_wr_acc, w_discard, w_drop_beat;
    logic                  w_auto_drop, w_mem_we, w_commit_last, w_load, w_pop_last;

    assign w_wr_uw      = r_wr_ptr - r_rd_ptr;
    assign w_uncmt      = r_wr_ptr - r_cmt_ptr;
    assign w_cmt_cnt    = r_cmt_ptr - r_rd_ptr;
    assign w_wr_ptr_nxt = r_wr_ptr + 1'b1;
    assign w_rd_uw      = {1'b0, w_cmt_cnt} + (ADDR_WIDTH+2)'(r_m_valid);

    assign w_full      = (w_wr_uw == c_full_cnt);
    assign w_discard   = (r_state == DISCARD);
    assign w_s_ready   = ~sclr & (w_discard | ~w_full);
    assign w_wr_acc    = s_valid & w_s_ready;
    assign w_drop_beat = PKT_MODE & s_drop;
    // A packet filling the whole store can never commit, so it is dropped
    assign w_auto_drop = PKT_MODE && (r_state == PKT) && (w_uncmt == c_full_cnt);
    assign w_mem_we      = w_wr_acc & ~w_discard & ~w_drop_beat;
    assign w_commit_last = w_mem_we & s_last;
    assign w_load        = ~sclr & (r_cmt_ptr != r_rd_ptr) & (~r_m_valid | m_ready);
    assign w_pop_last    = r_m_valid & m_ready & r_m_last;

    sync_fifo_pkt_mem #(
        .WORD_WIDTH (c_beat_w),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata ({s_last, s_data}),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata (w_rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_cmt_ptr <= '0;
            r_rd_ptr  <= '0;
            r_pkt_cnt <= '0;
            r_state   <= IDLE;
        end else if (sclr) begin
            r_wr_ptr  <= '0;
            r_cmt_ptr <= '0;
            r_rd_ptr  <= '0;
            r_pkt_cnt <= '0;
            r_state   <= IDLE;
        end else begin
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_commit_last && !w_pop_last) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end else if (!w_commit_last && w_pop_last) begin
                r_pkt_cnt <= r_pkt_cnt - 1'b1;
            end
            if (!PKT_MODE) begin
                if (w_wr_acc) begin
                    r_wr_ptr  <= w_wr_ptr_nxt;
                    r_cmt_ptr <= w_wr_ptr_nxt;
                end
            end else begin
                case (r_state)
                    IDLE, PKT: begin
                        if (w_auto_drop) begin
                            r_wr_ptr <= r_cmt_ptr;
                            r_state  <= DISCARD;
                        end else if (w_wr_acc) begin
                            if (s_drop) begin
                                r_wr_ptr <= r_cmt_ptr;
                                r_state  <= IDLE;
                            end else if (s_last) begin
                                r_wr_ptr  <= w_wr_ptr_nxt;
                                r_cmt_ptr <= w_wr_ptr_nxt;
                                r_state   <= IDLE;
                            end else begin
                                r_wr_ptr <= w_wr_ptr_nxt;
                                r_state  <= PKT;
                            end
                        end
                    end
                    DISCARD: begin
                        if (w_wr_acc && (s_last || s_drop)) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (sclr) begin
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (w_load) begin
            r_m_data  <= w_rd_word[DATA_WIDTH-1:0];
            r_m_last  <= w_rd_word[DATA_WIDTH];
            r_m_valid <= 1'b1;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    // Sticky errors: a new event in the clearing cycle takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_err  <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            if (s_valid && !w_s_ready && !sclr) begin
                r_ovf_err <= 1'b1;
            end else if (err_clr) begin
                r_ovf_err <= 1'b0;
            end
            if (w_auto_drop && !sclr) begin
                r_drop_err <= 1'b1;
            end else if (err_clr) begin
                r_drop_err <= 1'b0;
            end
        end
    end

    assign s_ready  = w_s_ready;
    assign m_data   = r_m_data;
    assign m_last   = r_m_last;
    assign m_valid  = r_m_valid;
    assign full     = w_full;
    assign empty    = ~r_m_valid;
    assign afull    = (w_wr_uw >= afull_thr);
    assign aempty   = (w_rd_uw <= aempty_thr);
    assign wr_uw    = w_wr_uw;
    assign rd_uw    = w_rd_uw;
    assign pkt_cnt  = r_pkt_cnt;
    assign ovf_err  = r_ovf_err;
    assign drop_err = r_drop_err;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_pkt.sv
// +-----------------------------------------------------------------------------
// | tb_sync_fifo_pkt : directed bench, packet-mode and word-mode instances
// | Rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_sync_fifo_pkt;

    logic       clk = 1'b0;
    logic       rst, sclr, s_last, s_drop, s_valid, m_ready, err_clr;
    logic [7:0] s_data;
    logic [2:0] afull_thr;
    logic [3:0] aempty_thr;

    logic       pk_s_ready, pk_m_last, pk_m_valid, pk_full, pk_empty, pk_afull, pk_aempty;
    logic       pk_ovf_err, pk_drop_err;
    logic [7:0] pk_m_data;
    logic [2:0] pk_wr_uw;
    logic [3:0] pk_rd_uw, pk_pkt_cnt;

    logic       wd_s_ready, wd_m_last, wd_m_valid, wd_full, wd_empty, wd_afull, wd_aempty;
    logic       wd_ovf_err, wd_drop_err;
    logic [7:0] wd_m_data;
    logic [2:0] wd_wr_uw;
    logic [3:0] wd_rd_uw, wd_pkt_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo_pkt #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .PKT_MODE(1'b1)) u_pk (
        .clk(clk), .rst(rst), .sclr(sclr), .s_data(s_data), .s_last(s_last), .s_drop(s_drop),
        .s_valid(s_valid), .s_ready(pk_s_ready), .m_data(pk_m_data), .m_last(pk_m_last),
        .m_valid(pk_m_valid), .m_ready(m_ready), .afull_thr(afull_thr), .aempty_thr(aempty_thr),
        .full(pk_full), .empty(pk_empty), .afull(pk_afull), .aempty(pk_aempty),
        .wr_uw(pk_wr_uw), .rd_uw(pk_rd_uw), .pkt_cnt(pk_pkt_cnt),
        .ovf_err(pk_ovf_err), .drop_err(pk_drop_err), .err_clr(err_clr)
    );

    sync_fifo_pkt #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .PKT_MODE(1'b0)) u_wd (
        .clk(clk), .rst(rst), .sclr(sclr), .s_data(s_data), .s_last(s_last), .s_drop(s_drop),
        .s_valid(s_valid), .s_ready(wd_s_ready), .m_data(wd_m_data), .m_last(wd_m_last),
        .m_valid(wd_m_valid), .m_ready(m_ready), .afull_thr(afull_thr), .aempty_thr(aempty_thr),
        .full(wd_full), .empty(wd_empty), .afull(wd_afull), .aempty(wd_aempty),
        .wr_uw(wd_wr_uw), .rd_uw(wd_rd_uw), .pkt_cnt(wd_pkt_cnt),
        .ovf_err(wd_ovf_err), .drop_err(wd_drop_err), .err_clr(err_clr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sclr = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_drop = 1'b0;
        m_ready = 1'b0; err_clr = 1'b0; s_data = 8'h00;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        afull_thr = 3'd3; aempty_thr = 4'd1;
        do_reset();
        checks++; if (pk_m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %0b want 0", pk_m_valid); end
        checks++; if (pk_m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %0h want 0", pk_m_data); end
        checks++; if (pk_s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %0b want 1", pk_s_ready); end
        checks++; if (pk_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", pk_empty); end
        checks++; if (pk_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", pk_full); end
        checks++; if (pk_wr_uw !== 3'd0) begin errors++; $display("FAIL reset_wr_uw: got %0d want 0", pk_wr_uw); end
        checks++; if (pk_rd_uw !== 4'd0) begin errors++; $display("FAIL reset_rd_uw: got %0d want 0", pk_rd_uw); end
        checks++; if (pk_pkt_cnt !== 4'd0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d want 0", pk_pkt_cnt); end
        checks++; if (pk_afull !== 1'b0) begin errors++; $display("FAIL reset_afull: got %0b want 0", pk_afull); end
        checks++; if (pk_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %0b want 1", pk_aempty); end
        checks++; if (pk_ovf_err !== 1'b0 || pk_drop_err !== 1'b0) begin errors++; $display("FAIL reset_errs: got ovf=%0b drop=%0b want 0 0", pk_ovf_err, pk_drop_err); end
    endtask

    task automatic test_commit();
        do_reset();
        m_ready = 1'b1; s_valid = 1'b1; s_last = 1'b0;
        s_data = 8'hA0; cyc();
        checks++; if (pk_m_valid !== 1'b0) begin errors++; $display("FAIL commit_a0_valid: got %0b want 0", pk_m_valid); end
        checks++; if (pk_wr_uw !== 3'd1) begin errors++; $display("FAIL commit_wr_uw: got %0d want 1", pk_wr_uw); end
        s_data = 8'hA1; cyc();
        checks++; if (pk_m_valid !== 1'b0) begin errors++; $display("FAIL commit_a1_valid: got %0b want 0", pk_m_valid); end
        s_data = 8'hA2; s_last = 1'b1; cyc();
        s_valid = 1'b0; s_last = 1'b0;
        checks++; if (pk_m_valid !== 1'b0) begin errors++; $display("FAIL commit_a2_valid: got %0b want 0", pk_m_valid); end
        checks++; if (pk_pkt_cnt !== 4'd1) begin errors++; $display("FAIL commit_pkt_cnt: got %0d want 1", pk_pkt_cnt); end
        checks++; if (pk_rd_uw !== 4'd3) begin errors++; $display("FAIL commit_rd_uw: got %0d want 3", pk_rd_uw); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++; if (pk_m_valid !== 1'b1 || pk_m_data !== 8'(8'hA0 + k) || pk_m_last !== (k == 2))
                begin errors++; $display("FAIL commit_out%0d: got v=%0b d=%0h l=%0b want v=1 d=%0h l=%0b", k, pk_m_valid, pk_m_data, pk_m_last, 8'(8'hA0 + k), (k == 2)); end
        end
        checks++; if (pk_pkt_cnt !== 4'd1) begin errors++; $display("FAIL commit_cnt_hold: got %0d want 1", pk_pkt_cnt); end
        cyc();
        checks++; if (pk_m_valid !== 1'b0 || pk_pkt_cnt !== 4'd0) begin errors++; $display("FAIL commit_drain: got v=%0b cnt=%0d want 0 0", pk_m_valid, pk_pkt_cnt); end
    endtask

    task automatic test_drop();
        do_reset();
        m_ready = 1'b1; s_valid = 1'b1; s_last = 1'b0;
        s_data = 8'hB0; cyc();
        checks++; if (pk_wr_uw !== 3'd1 || pk_m_valid !== 1'b0) begin errors++; $display("FAIL drop_b0: got uw=%0d v=%0b want 1 0", pk_wr_uw, pk_m_valid); end
        s_data = 8'hB1; cyc();
        checks++; if (pk_wr_uw !== 3'd2 || pk_m_valid !== 1'b0) begin errors++; $display("FAIL drop_b1: got uw=%0d v=%0b want 2 0", pk_wr_uw, pk_m_valid); end
        s_data = 8'hB2; s_drop = 1'b1; cyc();
        s_drop = 1'b0;
        checks++; if (pk_wr_uw !== 3'd0 || pk_pkt_cnt !== 4'd0 || pk_m_valid !== 1'b0)
            begin errors++; $display("FAIL drop_b2: got uw=%0d cnt=%0d v=%0b want 0 0 0", pk_wr_uw, pk_pkt_cnt, pk_m_valid); end
        s_data = 8'hC0; s_last = 1'b1; cyc();
        s_valid = 1'b0; s_last = 1'b0;
        checks++; if (pk_m_valid !== 1'b0 || pk_wr_uw !== 3'd1) begin errors++; $display("FAIL drop_c0_commit: got v=%0b uw=%0d want 0 1", pk_m_valid, pk_wr_uw); end
        cyc();
        checks++; if (pk_m_valid !== 1'b1 || pk_m_data !== 8'hC0 || pk_m_last !== 1'b1 || pk_pkt_cnt !== 4'd1)
            begin errors++; $display("FAIL drop_c0_out: got v=%0b d=%0h l=%0b cnt=%0d want 1 c0 1 1", pk_m_valid, pk_m_data, pk_m_last, pk_pkt_cnt); end
        cyc();
        checks++; if (pk_m_valid !== 1'b0 || pk_pkt_cnt !== 4'd0) begin errors++; $display("FAIL drop_drain: got v=%0b cnt=%0d want 0 0", pk_m_valid, pk_pkt_cnt); end
    endtask

    task automatic test_oversize();
        do_reset();
        m_ready = 1'b0; s_valid = 1'b1; s_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_data = 8'(8'hD0 + k); cyc();
        end
        s_valid = 1'b0;
        checks++; if (pk_full !== 1'b1 || pk_s_ready !== 1'b0 || pk_wr_uw !== 3'd4 || pk_drop_err !== 1'b0)
            begin errors++; $display("FAIL ovs_full: got f=%0b r=%0b uw=%0d de=%0b want 1 0 4 0", pk_full, pk_s_ready, pk_wr_uw, pk_drop_err); end
        cyc();
        checks++; if (pk_wr_uw !== 3'd0 || pk_drop_err !== 1'b1 || pk_s_ready !== 1'b1 || pk_m_valid !== 1'b0)
            begin errors++; $display("FAIL ovs_drop: got uw=%0d de=%0b r=%0b v=%0b want 0 1 1 0", pk_wr_uw, pk_drop_err, pk_s_ready, pk_m_valid); end
        s_valid = 1'b1; s_data = 8'hD4; cyc();
        s_data = 8'hD5; s_last = 1'b1; cyc();
        s_last = 1'b0;
        checks++; if (pk_wr_uw !== 3'd0 || pk_m_valid !== 1'b0 || pk_pkt_cnt !== 4'd0)
            begin errors++; $display("FAIL ovs_discard: got uw=%0d v=%0b cnt=%0d want 0 0 0", pk_wr_uw, pk_m_valid, pk_pkt_cnt); end
        s_data = 8'hE0; cyc();
        s_data = 8'hE1; s_last = 1'b1; cyc();
        s_valid = 1'b0; s_last = 1'b0;
        checks++; if (pk_pkt_cnt !== 4'd1 || pk_rd_uw !== 4'd2) begin errors++; $display("FAIL ovs_e_commit: got cnt=%0d rd=%0d want 1 2", pk_pkt_cnt, pk_rd_uw); end
        cyc();
        checks++; if (pk_m_valid !== 1'b1 || pk_m_data !== 8'hE0 || pk_m_last !== 1'b0)
            begin errors++; $display("FAIL ovs_e0: got v=%0b d=%0h l=%0b want 1 e0 0", pk_m_valid, pk_m_data, pk_m_last); end
        m_ready = 1'b1; cyc();
        checks++; if (pk_m_valid !== 1'b1 || pk_m_data !== 8'hE1 || pk_m_last !== 1'b1)
            begin errors++; $display("FAIL ovs_e1: got v=%0b d=%0h l=%0b want 1 e1 1", pk_m_valid, pk_m_data, pk_m_last); end
        cyc();
        checks++; if (pk_m_valid !== 1'b0 || pk_pkt_cnt !== 4'd0 || pk_ovf_err !== 1'b0)
            begin errors++; $display("FAIL ovs_end: got v=%0b cnt=%0d ovf=%0b want 0 0 0", pk_m_valid, pk_pkt_cnt, pk_ovf_err); end
    endtask

    task automatic test_sclr();
        m_ready = 1'b0; s_valid = 1'b1;
        s_data = 8'h50; s_last = 1'b0; cyc();
        s_data = 8'h51; s_last = 1'b1; cyc();
        s_data = 8'h60; s_last = 1'b0; cyc();
        s_valid = 1'b0;
        checks++; if (pk_m_valid !== 1'b1 || pk_wr_uw !== 3'd2 || pk_rd_uw !== 4'd2 || pk_pkt_cnt !== 4'd1)
            begin errors++; $display("FAIL sclr_pre: got v=%0b wr=%0d rd=%0d cnt=%0d want 1 2 2 1", pk_m_valid, pk_wr_uw, pk_rd_uw, pk_pkt_cnt); end
        sclr = 1'b1; #1;
        checks++; if (pk_s_ready !== 1'b0) begin errors++; $display("FAIL sclr_ready: got %0b want 0", pk_s_ready); end
        cyc();
        checks++; if (pk_m_valid !== 1'b0 || pk_wr_uw !== 3'd0 || pk_rd_uw !== 4'd0 || pk_pkt_cnt !== 4'd0)
            begin errors++; $display("FAIL sclr_clear: got v=%0b wr=%0d rd=%0d cnt=%0d want 0 0 0 0", pk_m_valid, pk_wr_uw, pk_rd_uw, pk_pkt_cnt); end
        checks++; if (pk_drop_err !== 1'b1) begin errors++; $display("FAIL sclr_sticky: got %0b want 1", pk_drop_err); end
        sclr = 1'b0;
        s_valid = 1'b1; s_data = 8'h70; s_last = 1'b1; cyc();
        s_valid = 1'b0; s_last = 1'b0; cyc();
        checks++; if (pk_m_valid !== 1'b1 || pk_m_data !== 8'h70 || pk_m_last !== 1'b1)
            begin errors++; $display("FAIL sclr_after: got v=%0b d=%0h l=%0b want 1 70 1", pk_m_valid, pk_m_data, pk_m_last); end
    endtask

    task automatic test_async_rst();
        m_ready = 1'b1; s_valid = 1'b1;
        s_data = 8'h80; s_last = 1'b0; cyc();
        s_data = 8'h81; s_last = 1'b1; cyc();
        s_data = 8'h82; s_last = 1'b0; cyc();
        checks++; if (pk_m_valid !== 1'b1 || pk_m_data !== 8'h80) begin errors++; $display("FAIL arst_pre: got v=%0b d=%0h want 1 80", pk_m_valid, pk_m_data); end
        #2 rst = 1'b1;
        #1;
        checks++; if (pk_m_valid !== 1'b0 || pk_m_data !== 8'h00 || pk_m_last !== 1'b0 || pk_empty !== 1'b1)
            begin errors++; $display("FAIL arst_out: got v=%0b d=%0h l=%0b e=%0b want 0 0 0 1", pk_m_valid, pk_m_data, pk_m_last, pk_empty); end
        checks++; if (pk_wr_uw !== 3'd0 || pk_rd_uw !== 4'd0 || pk_pkt_cnt !== 4'd0)
            begin errors++; $display("FAIL arst_cnt: got wr=%0d rd=%0d cnt=%0d want 0 0 0", pk_wr_uw, pk_rd_uw, pk_pkt_cnt); end
        checks++; if (pk_drop_err !== 1'b0 || pk_s_ready !== 1'b1)
            begin errors++; $display("FAIL arst_err: got de=%0b r=%0b want 0 1", pk_drop_err, pk_s_ready); end
        s_valid = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        checks++; if (pk_m_valid !== 1'b0) begin errors++; $display("FAIL arst_partial: got v=%0b want 0", pk_m_valid); end
    endtask

    task automatic test_word_full();
        do_reset();
        m_ready = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = 8'(i); s_last = (i == 4); cyc();
        end
        s_valid = 1'b0; s_last = 1'b0;
        checks++; if (wd_s_ready !== 1'b0 || wd_full !== 1'b1) begin errors++; $display("FAIL word_full: got r=%0b f=%0b want 0 1", wd_s_ready, wd_full); end
        checks++; if (wd_wr_uw !== 3'd4 || wd_rd_uw !== 4'd5) begin errors++; $display("FAIL word_counts: got wr=%0d rd=%0d want 4 5", wd_wr_uw, wd_rd_uw); end
        checks++; if (wd_ovf_err !== 1'b1 || wd_drop_err !== 1'b0) begin errors++; $display("FAIL word_errs: got ovf=%0b de=%0b want 1 0", wd_ovf_err, wd_drop_err); end
        checks++; if (wd_pkt_cnt !== 4'd1) begin errors++; $display("FAIL word_pkt_cnt: got %0d want 1", wd_pkt_cnt); end
        m_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (wd_m_valid !== 1'b1 || wd_m_data !== 8'(k) || wd_m_last !== (k == 4))
                begin errors++; $display("FAIL word_drain%0d: got v=%0b d=%0h l=%0b want 1 %0h %0b", k, wd_m_valid, wd_m_data, wd_m_last, k, (k == 4)); end
            cyc();
        end
        checks++; if (wd_m_valid !== 1'b0 || wd_pkt_cnt !== 4'd0 || wd_ovf_err !== 1'b1)
            begin errors++; $display("FAIL word_empty: got v=%0b cnt=%0d ovf=%0b want 0 0 1", wd_m_valid, wd_pkt_cnt, wd_ovf_err); end
        err_clr = 1'b1; cyc();
        err_clr = 1'b0;
        checks++; if (wd_ovf_err !== 1'b0) begin errors++; $display("FAIL word_err_clr: got %0b want 0", wd_ovf_err); end
    endtask

    task automatic test_thresholds();
        logic [2:0] e_wr;
        logic [3:0] e_rd;
        afull_thr = 3'd3; aempty_thr = 4'd1;
        do_reset();
        m_ready = 1'b0; s_valid = 1'b1; s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_data = 8'(8'h10 + i); cyc();
            e_wr = (i == 0) ? 3'd1 : 3'(i);
            e_rd = 4'(i + 1);
            checks++; if (wd_wr_uw !== e_wr || wd_rd_uw !== e_rd || wd_afull !== (e_wr >= 3'd3) || wd_aempty !== (e_rd <= 4'd1))
                begin errors++; $display("FAIL thr_fill%0d: got wr=%0d rd=%0d af=%0b ae=%0b want %0d %0d %0b %0b", i, wd_wr_uw, wd_rd_uw, wd_afull, wd_aempty, e_wr, e_rd, (e_wr >= 3'd3), (e_rd <= 4'd1)); end
        end
        s_valid = 1'b0; m_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            e_wr = (j < 3) ? 3'(2 - j) : 3'd0;
            e_rd = 4'(3 - j);
            checks++; if (wd_wr_uw !== e_wr || wd_rd_uw !== e_rd || wd_afull !== 1'b0 || wd_aempty !== (e_rd <= 4'd1))
                begin errors++; $display("FAIL thr_drain%0d: got wr=%0d rd=%0d af=%0b ae=%0b want %0d %0d 0 %0b", j, wd_wr_uw, wd_rd_uw, wd_afull, wd_aempty, e_wr, e_rd, (e_rd <= 4'd1)); end
            if (j < 3) begin
                checks++; if (wd_m_data !== 8'(8'h11 + j)) begin errors++; $display("FAIL thr_data%0d: got %0h want %0h", j, wd_m_data, 8'(8'h11 + j)); end
            end
        end
        checks++; if (wd_empty !== 1'b1) begin errors++; $display("FAIL thr_empty: got %0b want 1", wd_empty); end
    endtask

    initial begin
        test_reset();
        test_commit();
        test_drop();
        test_oversize();
        test_sclr();
        test_async_rst();
        test_word_full();
        test_thresholds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
